fpu_fp_narrow_pipe: RTL and testbench

- Pipelined, parametrised floating-point narrowing converter, e.g. binary64 to binary32.
- Replaces the combinational truncating converter. Adds IEEE-754 rounding (4 modes), gradual underflow to denormals, NaN/Inf handling and exception flags.
- Uses a valid/ready handshake so it can sit between the FPU register-read stage and the writeback arbiter.

---
 rtl/fpu_pkg.sv | 24 ++
 rtl/fpu_round_inc.sv | 28 ++
 rtl/fpu_fp_narrow_pipe.sv | 212 +++++++++++++++++++++
 tb/tb_fpu_fp_narrow_pipe.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding-mode encodings, exception flag bit positions
// and the operand class encoding used by the converters.
package fpu_pkg;

    localparam logic [1:0] FPU_RM_RNE = 2'd0;
    localparam logic [1:0] FPU_RM_RTZ = 2'd1;
    localparam logic [1:0] FPU_RM_RDN = 2'd2;
    localparam logic [1:0] FPU_RM_RUP = 2'd3;

    localparam int FPU_FLG_NX = 0;
    localparam int FPU_FLG_UF = 1;
    localparam int FPU_FLG_OF = 2;
    localparam int FPU_FLG_NV = 3;

    typedef enum logic [2:0] {
        FPU_CLS_ZERO,
        FPU_CLS_SUB,
        FPU_CLS_NORM,
        FPU_CLS_INF,
        FPU_CLS_QNAN,
        FPU_CLS_SNAN
    } fpu_class_e;

endpackage

// File: rtl/fpu_round_inc.sv
// Rounding decision: from the kept lsb, guard/round/sticky bits, sign and mode,
// decides whether the truncated magnitude is incremented and whether it was inexact.
module fpu_round_inc
    import fpu_pkg::*;
(
    input  logic       lsb,
    input  logic       guard,
    input  logic       round,
    input  logic       sticky,
    input  logic       sign,
    input  logic [1:0] rmode,
    output logic       inc,
    output logic       inexact
);

    always_comb begin
        inexact = guard | round | sticky;
        inc     = 1'b0;
        case (rmode)
            FPU_RM_RNE: inc = guard & (round | sticky | lsb);
            FPU_RM_RTZ: inc = 1'b0;
            FPU_RM_RDN: inc = sign & inexact;
            FPU_RM_RUP: inc = ~sign & inexact;
            default:    inc = 1'b0;
        endcase
    end

endmodule

// File: rtl/fpu_fp_narrow_pipe.sv
// Two-stage floating-point narrowing converter (e.g. binary64 -> binary32) with
// IEEE rounding, gradual underflow, NaN/Inf handling and per-result flags.
module fpu_fp_narrow_pipe
    import fpu_pkg::*;
#(
    parameter  int SRC_EXP  = 11,
    parameter  int SRC_FRAC = 52,
    parameter  int DST_EXP  = 8,
    parameter  int DST_FRAC = 23,
    localparam int SRC_W    = 1 + SRC_EXP + SRC_FRAC,
    localparam int DST_W    = 1 + DST_EXP + DST_FRAC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SRC_W-1:0] in_src,
    input  logic [1:0]       in_rmode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DST_W-1:0] out_dst,
    output logic [3:0]       out_flags
);

    localparam int EBW      = SRC_EXP + 2;
    localparam int MW       = SRC_FRAC + 3;
    localparam int SHW      = $clog2(DST_FRAC + 4);
    localparam int SRC_BIAS = 2**(SRC_EXP-1) - 1;
    localparam int DST_BIAS = 2**(DST_EXP-1) - 1;

    localparam logic signed [EBW-1:0] EB_OFFS = EBW'(DST_BIAS - SRC_BIAS);
    localparam logic signed [EBW-1:0] EB_MAX  = EBW'(2**DST_EXP - 2);
    localparam logic signed [EBW-1:0] EB_ONE  = EBW'(1);
    localparam logic signed [EBW-1:0] SH_SAT  = EBW'(DST_FRAC + 3);

    // ---------------- stage 1: unpack / rebias ----------------
    logic                src_sign;
    logic [SRC_EXP-1:0]  src_exp;
    logic [SRC_FRAC-1:0] src_frac;
    fpu_class_e          cls_in;

    assign {src_sign, src_exp, src_frac} = in_src;

    always_comb begin
        cls_in = FPU_CLS_NORM;
        if (src_exp == '0) begin
            cls_in = (src_frac == '0) ? FPU_CLS_ZERO : FPU_CLS_SUB;
        end else if (&src_exp) begin
            if (src_frac == '0)           cls_in = FPU_CLS_INF;
            else if (src_frac[SRC_FRAC-1]) cls_in = FPU_CLS_QNAN;
            else                           cls_in = FPU_CLS_SNAN;
        end
    end

    logic                  s1_valid_q, s1_valid_d;
    fpu_class_e            s1_cls_q, s1_cls_d;
    logic                  s1_sign_q, s1_sign_d;
    logic signed [EBW-1:0] s1_eb_q, s1_eb_d;
    logic [SRC_FRAC:0]     s1_mant_q, s1_mant_d;
    logic [1:0]            s1_rmode_q, s1_rmode_d;

    logic             out_valid_q, out_valid_d;
    logic [DST_W-1:0] out_dst_q, out_dst_d;
    logic [3:0]       out_flags_q, out_flags_d;

    logic s2_adv, s1_adv;

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = !s1_valid_q || s1_adv;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_cls_d   = s1_cls_q;
        s1_sign_d  = s1_sign_q;
        s1_eb_d    = s1_eb_q;
        s1_mant_d  = s1_mant_q;
        s1_rmode_d = s1_rmode_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_cls_d   = cls_in;
                s1_sign_d  = src_sign;
                s1_eb_d    = $signed({2'b00, src_exp}) + EB_OFFS;
                s1_mant_d  = {src_exp != '0, src_frac};
                s1_rmode_d = in_rmode;
            end
        end
    end

    // ---------------- stage 2: round / pack ----------------
    logic                  tiny, big, ovf, to_inf;
    logic signed [EBW-1:0] one_m_eb;
    logic [SHW-1:0]        sh;
    logic [MW-1:0]         w, w_sh, lost_mask;
    logic                  lost;
    logic [DST_FRAC:0]     sig;
    logic                  g, r, s, inc, nx;
    logic [DST_FRAC+1:0]   sum;
    logic [DST_EXP-1:0]    exp_rnd;
    logic [DST_W-2:0]      max_mag, inf_mag;
    logic [DST_W-1:0]      res;
    logic [3:0]            flg;

    fpu_round_inc u_round_inc (
        .lsb     (sig[0]),
        .guard   (g),
        .round   (r),
        .sticky  (s),
        .sign    (s1_sign_q),
        .rmode   (s1_rmode_q),
        .inc     (inc),
        .inexact (nx)
    );

    always_comb begin
        tiny     = (s1_eb_q < EB_ONE) || (s1_cls_q == FPU_CLS_SUB);
        big      = s1_eb_q > EB_MAX;
        one_m_eb = EB_ONE - s1_eb_q;

        // source denormals are far below range: push every bit into sticky
        if (!tiny)                                        sh = '0;
        else if (s1_cls_q == FPU_CLS_SUB || one_m_eb > SH_SAT) sh = SHW'(DST_FRAC + 3);
        else                                              sh = one_m_eb[SHW-1:0];

        w         = {s1_mant_q, 2'b00};
        w_sh      = w >> sh;
        lost_mask = ~({MW{1'b1}} << sh);
        lost      = |(w & lost_mask);
        sig       = w_sh[MW-1 -: DST_FRAC+1];
        g         = w_sh[MW-DST_FRAC-2];
        r         = w_sh[MW-DST_FRAC-3];
        s         = (|w_sh[MW-DST_FRAC-4:0]) | lost;

        sum     = {1'b0, sig} + {{(DST_FRAC+1){1'b0}}, inc};
        exp_rnd = s1_eb_q[DST_EXP-1:0] + {{(DST_EXP-1){1'b0}}, sum[DST_FRAC+1]};
        ovf     = big || (!tiny && sum[DST_FRAC+1] && (s1_eb_q == EB_MAX));
        to_inf  = (s1_rmode_q == FPU_RM_RNE) ||
                  ((s1_rmode_q == FPU_RM_RUP) && !s1_sign_q) ||
                  ((s1_rmode_q == FPU_RM_RDN) && s1_sign_q);
        max_mag = {{(DST_EXP-1){1'b1}}, 1'b0, {DST_FRAC{1'b1}}};
        inf_mag = {{DST_EXP{1'b1}}, {DST_FRAC{1'b0}}};

        res = '0;
        flg = '0;
        case (s1_cls_q)
            FPU_CLS_ZERO: res = {s1_sign_q, {(DST_W-1){1'b0}}};
            FPU_CLS_INF:  res = {s1_sign_q, inf_mag};
            FPU_CLS_QNAN, FPU_CLS_SNAN: begin
                res = {s1_sign_q, {DST_EXP{1'b1}}, 1'b1, s1_mant_q[SRC_FRAC-2 -: DST_FRAC-1]};
                flg[FPU_FLG_NV] = (s1_cls_q == FPU_CLS_SNAN);
            end
            default: begin
                if (ovf) begin
                    res = {s1_sign_q, to_inf ? inf_mag : max_mag};
                    flg[FPU_FLG_OF] = 1'b1;
                    flg[FPU_FLG_NX] = 1'b1;
                end else if (tiny) begin
                    // a carry into the hidden position lands on exponent field 1
                    res = {s1_sign_q, {(DST_EXP-1){1'b0}}, sum[DST_FRAC:0]};
                    flg[FPU_FLG_NX] = nx;
                    flg[FPU_FLG_UF] = nx;
                end else begin
                    res = {s1_sign_q, exp_rnd, sum[DST_FRAC-1:0]};
                    flg[FPU_FLG_NX] = nx;
                end
            end
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_dst_d   = out_dst_q;
        out_flags_d = out_flags_q;
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_dst_d   = res;
                out_flags_d = flg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid_q  <= 1'b0;
            s1_cls_q    <= FPU_CLS_ZERO;
            s1_sign_q   <= 1'b0;
            s1_eb_q     <= '0;
            s1_mant_q   <= '0;
            s1_rmode_q  <= FPU_RM_RNE;
            out_valid_q <= 1'b0;
            out_dst_q   <= '0;
            out_flags_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_cls_q    <= s1_cls_d;
            s1_sign_q   <= s1_sign_d;
            s1_eb_q     <= s1_eb_d;
            s1_mant_q   <= s1_mant_d;
            s1_rmode_q  <= s1_rmode_d;
            out_valid_q <= out_valid_d;
            out_dst_q   <= out_dst_d;
            out_flags_q <= out_flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_dst   = out_dst_q;
    assign out_flags = out_flags_q;

endmodule

// File: tb/tb_fpu_fp_narrow_pipe.sv
// Bench for the binary64 -> binary32 narrowing pipe: directed corner cases, stall
// behaviour, reset, and random traffic checked against an exact-arithmetic model.
module tb_fpu_fp_narrow_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_src = '0;
    logic [1:0]  in_rmode = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_dst;
    logic [3:0]  out_flags;

    int n_checks = 0;
    int n_pass   = 0;
    logic [35:0] exp_q[$];

    always #5 clk = ~clk;

    fpu_fp_narrow_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_src    (in_src),
        .in_rmode  (in_rmode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dst   (out_dst),
        .out_flags (out_flags)
    );

    // Exact model: value = M * 2^E, quantised to the binary32 grid by integer
    // division with remainder; returns {flags, result}.
    function automatic logic [35:0] ref_conv(input logic [63:0] src, input logic [1:0] rm);
        logic        sgn;
        int          ex, e32, q, k;
        logic [51:0] fr;
        logic [31:0] res;
        logic [3:0]  fl;
        logic [63:0] m, qv, rem, half;
        bit          tiny, up, ovf, away;
        sgn  = src[63];
        ex   = int'(src[62:52]);
        fr   = src[51:0];
        fl   = 4'h0;
        res  = '0;
        away = (rm == 2'd0) || (rm == 2'd3 && !sgn) || (rm == 2'd2 && sgn);
        if (ex == 2047) begin
            if (fr == '0) res = {sgn, 8'hFF, 23'h0};
            else begin
                res = {sgn, 8'hFF, 1'b1, fr[50:29]};
                if (!fr[51]) fl = 4'h8;
            end
        end else if (ex == 0) begin
            if (fr == '0) res = {sgn, 31'h0};
            else begin
                up  = (rm == 2'd3 && !sgn) || (rm == 2'd2 && sgn);
                res = {sgn, 30'h0, up};
                fl  = 4'h3;
            end
        end else begin
            m    = {11'h0, 1'b1, fr};
            e32  = ex - 1023;
            tiny = e32 < -126;
            q    = tiny ? -149 : e32 - 23;
            k    = q - (e32 - 52);
            if (k >= 63) begin
                qv = '0; rem = m; half = 64'hFFFF_FFFF_FFFF_FFFF;
            end else begin
                qv   = m >> k;
                rem  = m & ((64'h1 << k) - 64'h1);
                half = 64'h1 << (k - 1);
            end
            case (rm)
                2'd0:    up = (rem > half) || (rem == half && qv[0]);
                2'd1:    up = 1'b0;
                2'd2:    up = sgn && rem != 0;
                default: up = !sgn && rem != 0;
            endcase
            if (up) qv = qv + 64'h1;
            if (!tiny && qv == (64'h1 << 24)) begin
                qv  = 64'h1 << 23;
                e32 = e32 + 1;
            end
            ovf = !tiny && (e32 + 127 >= 255);
            if (rem != 0) fl[0] = 1'b1;
            if (tiny && rem != 0) fl[1] = 1'b1;
            if (ovf) begin
                fl  = 4'h5;
                res = away ? {sgn, 8'hFF, 23'h0} : {sgn, 8'hFE, 23'h7FFFFF};
            end else if (tiny) begin
                res = {sgn, 31'(qv)};
            end else begin
                res = {sgn, 8'(e32 + 127), 23'(qv - (64'h1 << 23))};
            end
        end
        return {fl, res};
    endfunction

    function automatic logic [63:0] rand_src();
        logic [63:0] v;
        int sel, e;
        v   = {$urandom, $urandom};
        sel = $urandom_range(0, 15);
        case (sel)
            0:          e = 0;
            1:          e = 2047;
            2, 3, 4:    e = 868 + $urandom_range(0, 35);
            5, 6:       e = 1143 + $urandom_range(0, 10);
            default:    e = 897 + $urandom_range(0, 253);
        endcase
        v[62:52] = 11'(e);
        if ($urandom_range(0, 3) == 0) v[27:0] = '0;
        return v;
    endfunction

    task automatic test_reset();
        reset    = 1'b0;
        in_valid = 1'b1;
        in_src   = 64'h3FF0000000000000;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset out_valid: got %b expected 0", out_valid);
        else n_pass++;
        n_checks++;
        if (out_dst !== 32'h0 || out_flags !== 4'h0)
            $display("FAIL reset outputs: got %h/%h expected 0/0", out_dst, out_flags);
        else n_pass++;
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset in_ready: got %b expected 1", in_ready);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [63:0] src;
        logic [1:0]  rm;
        logic [31:0] dst;
        logic [3:0]  flg;
    } vec_t;

    task automatic test_directed();
        vec_t vecs[$];
        vecs.push_back('{64'h3FF0000000000000, 2'd0, 32'h3F800000, 4'h0});
        vecs.push_back('{64'h3FF0000010000000, 2'd0, 32'h3F800000, 4'h1});
        vecs.push_back('{64'h3FF0000010000000, 2'd3, 32'h3F800001, 4'h1});
        vecs.push_back('{64'h3FF0000010000000, 2'd1, 32'h3F800000, 4'h1});
        vecs.push_back('{64'h3FF0000030000000, 2'd0, 32'h3F800002, 4'h1});
        vecs.push_back('{64'h47F0000000000000, 2'd0, 32'h7F800000, 4'h5});
        vecs.push_back('{64'h47F0000000000000, 2'd1, 32'h7F7FFFFF, 4'h5});
        vecs.push_back('{64'hC7F0000000000000, 2'd3, 32'hFF7FFFFF, 4'h5});
        vecs.push_back('{64'h47EFFFFFFFFFFFFF, 2'd0, 32'h7F800000, 4'h5});
        vecs.push_back('{64'h36A0000000000000, 2'd0, 32'h00000001, 4'h0});
        vecs.push_back('{64'h3690000000000000, 2'd0, 32'h00000000, 4'h3});
        vecs.push_back('{64'h3690000000000000, 2'd3, 32'h00000001, 4'h3});
        vecs.push_back('{64'h7FF0000000000001, 2'd0, 32'h7FC00000, 4'h8});
        vecs.push_back('{64'hFFF8000000000000, 2'd0, 32'hFFC00000, 4'h0});
        vecs.push_back('{64'h8000000000000001, 2'd2, 32'h80000001, 4'h3});
        vecs.push_back('{64'h0000000000000001, 2'd0, 32'h00000000, 4'h3});
        vecs.push_back('{64'h8000000000000000, 2'd0, 32'h80000000, 4'h0});
        vecs.push_back('{64'hFFF0000000000000, 2'd2, 32'hFF800000, 4'h0});
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            in_valid = 1'b1;
            in_src   = vecs[i].src;
            in_rmode = vecs[i].rm;
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b1) $display("FAIL directed[%0d] in_ready: got %b expected 1", i, in_ready);
            else n_pass++;
            @(posedge clk); #1;
            in_valid = 1'b0;
            n_checks++;
            if (out_valid !== 1'b0) $display("FAIL directed[%0d] early out_valid: got %b expected 0", i, out_valid);
            else n_pass++;
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1) $display("FAIL directed[%0d] latency out_valid: got %b expected 1", i, out_valid);
            else n_pass++;
            n_checks++;
            if (out_dst !== vecs[i].dst)
                $display("FAIL directed[%0d] dst: got %h expected %h", i, out_dst, vecs[i].dst);
            else n_pass++;
            n_checks++;
            if (out_flags !== vecs[i].flg)
                $display("FAIL directed[%0d] flags: got %h expected %h", i, out_flags, vecs[i].flg);
            else n_pass++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        logic [63:0] w[5];
        logic [1:0]  m[5];
        logic [35:0] e;
        logic [31:0] held_dst;
        logic [3:0]  held_flg;
        bit          held;
        int          idx, got, cyc;
        exp_q.delete();
        out_ready = 1'b0;
        held = 1'b0;
        idx  = 0;
        held_dst = '0;
        held_flg = '0;
        for (int i = 0; i < 5; i++) begin
            w[i] = rand_src();
            m[i] = 2'($urandom_range(0, 3));
            exp_q.push_back(ref_conv(w[i], m[i]));
        end
        for (int c = 0; c < 6; c++) begin
            in_valid = (idx < 5);
            if (idx < 5) begin in_src = w[idx]; in_rmode = m[idx]; end
            @(negedge clk);
            if (out_valid) begin
                if (held) begin
                    n_checks++;
                    if (out_dst !== held_dst || out_flags !== held_flg)
                        $display("FAIL stall hold: got %h/%h expected %h/%h", out_dst, out_flags, held_dst, held_flg);
                    else n_pass++;
                end else begin
                    held = 1'b1; held_dst = out_dst; held_flg = out_flags;
                end
            end
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (idx != 2) $display("FAIL stall accepts: got %0d expected 2", idx);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL stall in_ready: got %b expected 0", in_ready);
        else n_pass++;
        @(posedge clk); #1;
        out_ready = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 5 && cyc < 100) begin
            in_valid = (idx < 5);
            if (idx < 5) begin in_src = w[idx]; in_rmode = m[idx]; end
            @(negedge clk);
            if (out_valid) begin
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL stall extra word: got %h expected none", out_dst);
                else begin
                    e = exp_q.pop_front();
                    if ({out_flags, out_dst} !== e)
                        $display("FAIL stall order word %0d: got %h_%h expected %h", got, out_flags, out_dst, e);
                    else n_pass++;
                end
                got++;
            end
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (got != 5) $display("FAIL stall drain count: got %0d expected 5", got);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [35:0] e;
        logic [35:0] prev;
        bit          prev_stall;
        int          sent, got, cyc;
        int          total = 400;
        exp_q.delete();
        sent = 0; got = 0; cyc = 0;
        prev_stall = 1'b0;
        prev = '0;
        in_valid = 1'b0;
        while (got < total && cyc < 5000) begin
            @(negedge clk);
            if (prev_stall && out_valid) begin
                n_checks++;
                if ({out_flags, out_dst} !== prev)
                    $display("FAIL random hold: got %h_%h expected %h", out_flags, out_dst, prev);
                else n_pass++;
            end
            prev_stall = out_valid && !out_ready;
            prev = {out_flags, out_dst};
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL random extra word: got %h expected none", out_dst);
                else begin
                    e = exp_q.pop_front();
                    if ({out_flags, out_dst} !== e)
                        $display("FAIL random word %0d: got %h_%h expected %h", got, out_flags, out_dst, e);
                    else n_pass++;
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_conv(in_src, in_rmode));
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
            in_valid = (sent < total) && ($urandom_range(0, 3) != 0);
            if (in_valid) begin
                in_src   = rand_src();
                in_rmode = 2'($urandom_range(0, 3));
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (got != total) $display("FAIL random completion: got %0d expected %0d", got, total);
        else n_pass++;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        exp_q.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_src   = rand_src();
            in_rmode = 2'($urandom_range(0, 3));
            @(posedge clk); #1;
        end
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL midreset out_valid: got %b expected 0", out_valid);
        else n_pass++;
        n_checks++;
        if (out_dst !== 32'h0 || out_flags !== 4'h0)
            $display("FAIL midreset outputs: got %h/%h expected 0/0", out_dst, out_flags);
        else n_pass++;
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL midreset in_ready: got %b expected 1", in_ready);
        else n_pass++;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) $display("FAIL midreset stale word cycle %0d: got %b expected 0", c, out_valid);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
